// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and steps every instruction through
// fetch -> execute -> commit, producing the one-cycle commit strobe.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int unsigned       EXEC_CYCLES = 2,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               stall,
  input  logic               halt_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pcPlus1,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               pulse_en,
  output logic [31:0]        instret,
  output logic               halted,
  output logic               fetch_err
);

  // Counter widths sized so each counter can hold its terminal value.
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned EXEC_W = $clog2(EXEC_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_COMMIT = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [EXEC_W-1:0]   r_exec_cnt;
  logic [ADDR_W-1:0]   r_pc;
  logic [INSTR_W-1:0]  r_instr;
  logic [31:0]         r_instret;
  logic                r_fetch_err;
  logic                r_imem_req;
  logic                r_instr_valid;
  logic                r_pulse_en;
  logic                r_halted;

  logic                w_capture;
  logic                w_timeout;
  logic                w_commit;
  logic                w_fetch_entry;

  // State register.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the per-state events that drive the datapath.
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack) begin
          w_capture    = 1'b1;
          w_next_state = S_EXEC;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_next_state = S_HALT;
        end
      end
      S_EXEC: begin
        if ((r_exec_cnt == '0) && !stall) begin
          w_next_state = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit     = 1'b1;
        w_next_state = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign w_fetch_entry = (w_next_state == S_FETCH) && (r_state != S_FETCH);

  // Fetch wait counter: cleared on entry to FETCH, counts cycles without ack.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_wait_cnt <= '0;
    end else if (w_fetch_entry) begin
      r_wait_cnt <= '0;
    end else if ((r_state == S_FETCH) && !imem_ack && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Execute counter: loaded on capture, counts down to zero and holds there.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_exec_cnt <= '0;
    end else if (w_capture) begin
      r_exec_cnt <= EXEC_W'(EXEC_CYCLES - 1);
    end else if ((r_state == S_EXEC) && (r_exec_cnt != '0)) begin
      r_exec_cnt <= r_exec_cnt - EXEC_W'(1);
    end
  end

  // Instruction register: loads only on an acknowledged fetch.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_instr <= '0;
    end else if (w_capture) begin
      r_instr <= imem_rdata;
    end
  end

  // Architectural commit: PC update and retired-instruction count.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_pc      <= RESET_PC;
      r_instret <= '0;
    end else if (w_commit) begin
      r_pc      <= pc_next;
      r_instret <= r_instret + 32'd1;
    end
  end

  // Sticky fetch-timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_fetch_err <= 1'b0;
    end else if (w_timeout) begin
      r_fetch_err <= 1'b1;
    end
  end

  // State-decoded strobes registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_pulse_en    <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_imem_req    <= (w_next_state == S_FETCH);
      r_instr_valid <= (w_next_state == S_EXEC) || (w_next_state == S_COMMIT);
      r_pulse_en    <= (w_next_state == S_COMMIT);
      r_halted      <= (w_next_state == S_HALT);
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pcPlus1     = r_pc + ADDR_W'(1);
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;
  assign pulse_en    = r_pulse_en;
  assign instret     = r_instret;
  assign halted      = r_halted;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed cycle tables, corner sequences and
// randomized instruction streams scored against an instruction-level model.
module tb_fetch_sequencer;

  localparam int unsigned TB_EXEC = 2;
  localparam int unsigned TB_TO   = 6;
  localparam logic [31:0] RST_PC  = 32'h0;

  localparam int P_IDLE   = 0;
  localparam int P_FETCH  = 1;
  localparam int P_EXEC   = 2;
  localparam int P_COMMIT = 3;
  localparam int P_HALT   = 4;

  typedef struct {
    logic        clr_n;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        halt;
    logic [31:0] pcn;
    int          ph;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
    logic        err;
  } vec_t;

  logic        clk;
  logic        clr_n;
  logic [31:0] pc_next;
  logic        stall;
  logic        halt_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pcPlus1;
  logic [31:0] instr;
  logic        instr_valid;
  logic        pulse_en;
  logic [31:0] instret;
  logic        halted;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  fetch_sequencer #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(RST_PC),
    .EXEC_CYCLES(TB_EXEC), .TIMEOUT(TB_TO)
  ) dut (
    .clk(clk), .clr_n(clr_n), .pc_next(pc_next), .stall(stall),
    .halt_req(halt_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .pcPlus1(pcPlus1),
    .instr(instr), .instr_valid(instr_valid), .pulse_en(pulse_en),
    .instret(instret), .halted(halted), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t v(input logic c, input logic a, input logic [31:0] rd,
                             input logic s, input logic h, input logic [31:0] pn,
                             input int ph, input logic [31:0] epc,
                             input logic [31:0] ein, input logic [31:0] eret,
                             input logic eerr);
    vec_t x;
    x.clr_n = c; x.ack = a; x.rdata = rd; x.stall = s; x.halt = h; x.pcn = pn;
    x.ph = ph; x.pc = epc; x.instr = ein; x.ret = eret; x.err = eerr;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Check the current cycle's outputs, then drive this cycle's inputs and advance.
  task automatic apply(input vec_t x);
    chk("imem_req",    32'(imem_req),    32'(x.ph == P_FETCH));
    chk("instr_valid", 32'(instr_valid), 32'(x.ph == P_EXEC || x.ph == P_COMMIT));
    chk("pulse_en",    32'(pulse_en),    32'(x.ph == P_COMMIT));
    chk("halted",      32'(halted),      32'(x.ph == P_HALT));
    chk("fetch_err",   32'(fetch_err),   32'(x.err));
    chk("pc",          pc,               x.pc);
    chk("imem_addr",   imem_addr,        x.pc);
    chk("pcPlus1",     pcPlus1,          x.pc + 32'd1);
    chk("instr",       instr,            x.instr);
    chk("instret",     instret,          x.ret);
    clr_n      = x.clr_n;
    imem_ack   = x.ack;
    imem_rdata = x.rdata;
    stall      = x.stall;
    halt_req   = x.halt;
    pc_next    = x.pcn;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    clr_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    stall = 1'b0; halt_req = 1'b0; pc_next = 32'h7;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Instruction-level reference: each instruction is fetch (ack delay + 1),
  // exec (EXEC_CYCLES plus any stalled cycles after the countdown), commit (1).
  vec_t        rq[$];
  logic [31:0] m_pc, m_instr, m_ret;
  logic        m_err;

  task automatic put(input logic a, input logic [31:0] rd, input logic s,
                     input logic h, input logic [31:0] pn, input int ph);
    rq.push_back(v(1'b1, a, rd, s, h, pn, ph, m_pc, m_instr, m_ret, m_err));
  endtask

  task automatic gen_stream(input int n_instr);
    logic [31:0] r, pn;
    int d, s;
    logic h;
    m_pc = RST_PC; m_instr = '0; m_ret = '0; m_err = 1'b0;
    put(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, P_IDLE);
    for (int k = 0; k < n_instr; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < int'(TB_TO); j++)
          put(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom, P_FETCH);
        m_err = 1'b1;
        for (int j = 0; j < 3; j++)
          put(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, P_HALT);
        return;
      end
      d = $urandom_range(0, 4);
      for (int j = 0; j < d; j++)
        put(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom, P_FETCH);
      r = $urandom;
      put(1'b1, r, 1'($urandom), 1'($urandom), $urandom, P_FETCH);
      m_instr = r;
      for (int j = 0; j < int'(TB_EXEC) - 1; j++)
        put(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, P_EXEC);
      s = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : 0;
      for (int j = 0; j < s; j++)
        put(1'($urandom), $urandom, 1'b1, 1'($urandom), $urandom, P_EXEC);
      put(1'($urandom), $urandom, 1'b0, 1'($urandom), $urandom, P_EXEC);
      h = (k == n_instr - 1) || ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0:       pn = m_pc + 32'd1;
        1:       pn = m_pc;
        2:       pn = $urandom;
        default: pn = 32'hFFFF_FFFF;
      endcase
      put(1'($urandom), $urandom, 1'($urandom), h, pn, P_COMMIT);
      m_pc  = pn;
      m_ret = m_ret + 32'd1;
      if (h) begin
        for (int j = 0; j < 3; j++)
          put(1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, P_HALT);
        return;
      end
    end
  endtask

  vec_t dir[$];

  initial begin
    // Directed table: back-to-back fetches, delayed ack, stall, jump, wrap, halt.
    dir.push_back(v(1, 1, 32'hDEAD, 0, 0, 0,            P_IDLE,   32'h0,        32'h0,        0, 0));
    dir.push_back(v(1, 1, 32'hA000_0000, 0, 0, 0,       P_FETCH,  32'h0,        32'h0,        0, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h0,        32'hA000_0000, 0, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h0,        32'hA000_0000, 0, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 32'h1,               P_COMMIT, 32'h0,        32'hA000_0000, 0, 0));
    dir.push_back(v(1, 1, 32'hA000_0001, 0, 0, 0,       P_FETCH,  32'h1,        32'hA000_0000, 1, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h1,        32'hA000_0001, 1, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h1,        32'hA000_0001, 1, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 32'h2,               P_COMMIT, 32'h1,        32'hA000_0001, 1, 0));
    dir.push_back(v(1, 0, 32'h1111, 0, 0, 0,            P_FETCH,  32'h2,        32'hA000_0001, 2, 0));
    dir.push_back(v(1, 0, 32'h2222, 0, 0, 0,            P_FETCH,  32'h2,        32'hA000_0001, 2, 0));
    dir.push_back(v(1, 0, 32'h3333, 0, 0, 0,            P_FETCH,  32'h2,        32'hA000_0001, 2, 0));
    dir.push_back(v(1, 1, 32'hA000_0002, 0, 0, 0,       P_FETCH,  32'h2,        32'hA000_0001, 2, 0));
    dir.push_back(v(1, 1, 32'h4444, 0, 0, 0,            P_EXEC,   32'h2,        32'hA000_0002, 2, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h2,        32'hA000_0002, 2, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 32'h40,              P_COMMIT, 32'h2,        32'hA000_0002, 2, 0));
    dir.push_back(v(1, 1, 32'hA000_0003, 0, 0, 0,       P_FETCH,  32'h40,       32'hA000_0002, 3, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h40,       32'hA000_0003, 3, 0));
    for (int i = 0; i < 5; i++)
      dir.push_back(v(1, 0, 0, 1, 0, 0,                 P_EXEC,   32'h40,       32'hA000_0003, 3, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'h40,       32'hA000_0003, 3, 0));
    dir.push_back(v(1, 0, 0, 1, 0, 32'hFFFF_FFFF,       P_COMMIT, 32'h40,       32'hA000_0003, 3, 0));
    dir.push_back(v(1, 1, 32'hA000_0004, 0, 0, 0,       P_FETCH,  32'hFFFF_FFFF, 32'hA000_0003, 4, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'hFFFF_FFFF, 32'hA000_0004, 4, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_EXEC,   32'hFFFF_FFFF, 32'hA000_0004, 4, 0));
    dir.push_back(v(1, 0, 0, 0, 1, 32'h5,               P_COMMIT, 32'hFFFF_FFFF, 32'hA000_0004, 4, 0));
    dir.push_back(v(1, 1, 32'h5555, 0, 0, 32'h9,        P_HALT,   32'h5,        32'hA000_0004, 5, 0));
    dir.push_back(v(1, 1, 32'h6666, 1, 1, 32'h9,        P_HALT,   32'h5,        32'hA000_0004, 5, 0));
    dir.push_back(v(1, 0, 0, 0, 0, 0,                   P_HALT,   32'h5,        32'hA000_0004, 5, 0));

    do_reset();
    foreach (dir[i]) apply(dir[i]);

    // Fetch timeout, reset out of HALT, reset mid-fetch with a late ack.
    do_reset();
    apply(v(1, 0, 0, 0, 0, 0, P_IDLE, RST_PC, 0, 0, 0));
    for (int i = 0; i < int'(TB_TO); i++)
      apply(v(1, 0, $urandom, 1, 1, $urandom, P_FETCH, RST_PC, 0, 0, 0));
    apply(v(1, 1, 32'h1234, 0, 0, 0, P_HALT, RST_PC, 0, 0, 1));
    apply(v(0, 1, 32'h1234, 0, 0, 0, P_HALT, RST_PC, 0, 0, 1));
    apply(v(1, 0, 0, 0, 0, 0, P_IDLE, RST_PC, 0, 0, 0));
    apply(v(1, 0, 0, 0, 0, 0, P_FETCH, RST_PC, 0, 0, 0));
    apply(v(0, 1, 32'hDEAD_BEEF, 0, 0, 0, P_FETCH, RST_PC, 0, 0, 0));
    apply(v(1, 1, 32'hBEEF_0001, 0, 0, 0, P_IDLE, RST_PC, 0, 0, 0));
    apply(v(1, 0, 0, 0, 0, 0, P_FETCH, RST_PC, 0, 0, 0));
    apply(v(1, 1, 32'hC0DE, 0, 0, 0, P_FETCH, RST_PC, 0, 0, 0));
    apply(v(1, 0, 0, 0, 0, 0, P_EXEC, RST_PC, 32'hC0DE, 0, 0));

    // Randomized instruction streams, each started from reset.
    for (int b = 0; b < 25; b++) begin
      rq.delete();
      gen_stream(12);
      do_reset();
      foreach (rq[i]) apply(rq[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
